// File: rtl/serial_logic16.sv
// serial_logic16: bit-serial 16-bit bitwise logic unit (AND/OR/XOR/NAND).
// Operands are latched on an input handshake and processed one bit per clock,
// LSB first, through a single shared 1-bit gate. The result is presented
// behind a valid/ready handshake.
// Optional feature macro: SERIAL_LOGIC_FLAGS_EN adds the zr/ng result flags.
module serial_logic16 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out
`ifdef SERIAL_LOGIC_FLAGS_EN
  ,
  output logic             zr,
  output logic             ng
`endif
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;

  logic [1:0]       state;
  logic [1:0]       next_state;
  logic [WIDTH-1:0] xs;
  logic [WIDTH-1:0] ys;
  logic [WIDTH-1:0] res;
  logic [1:0]       op_q;
  logic [CNT_W-1:0] cnt;

  logic             bit_c;
  logic             accept_c;
  logic             last_c;
  logic             handoff_c;
  logic [WIDTH-1:0] res_next_c;

  // Shared 1-bit gate plus the handshake/terminal-count decodes
  always_comb begin
    bit_c = 1'b0;
    case (op_q)
      OP_AND:  bit_c = xs[0] & ys[0];
      OP_OR:   bit_c = xs[0] | ys[0];
      OP_XOR:  bit_c = xs[0] ^ ys[0];
      default: bit_c = ~(xs[0] & ys[0]);
    endcase
    res_next_c = {bit_c, res[WIDTH-1:1]};
    accept_c   = (state == S_IDLE) && in_valid;
    last_c     = (state == S_RUN) && (cnt == CNT_W'(WIDTH - 1));
    handoff_c  = (state == S_DONE) && out_valid && out_ready;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (accept_c)  next_state = S_RUN;
      S_RUN:  if (last_c)    next_state = S_DONE;
      S_DONE: if (handoff_c) next_state = S_IDLE;
      default:               next_state = S_IDLE;
    endcase
  end

  // Operand shift registers, result accumulator and bit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xs   <= '0;
      ys   <= '0;
      res  <= '0;
      op_q <= 2'b00;
      cnt  <= '0;
    end else if (accept_c) begin
      xs   <= x;
      ys   <= y;
      res  <= '0;
      op_q <= op;
      cnt  <= '0;
    end else if (state == S_RUN) begin
      xs   <= xs >> 1;
      ys   <= ys >> 1;
      res  <= res_next_c;
      cnt  <= cnt + CNT_W'(1);
    end
  end

  // Registered handshake outputs; out_valid rises one clock after DONE entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else if (accept_c) begin
      in_ready  <= 1'b0;
    end else if (handoff_c) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else if (state == S_DONE) begin
      out_valid <= 1'b1;
    end
  end

  // Result register, loaded with the final bit on the RUN->DONE edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= '0;
    end else if (last_c) begin
      out <= res_next_c;
    end
  end

`ifdef SERIAL_LOGIC_FLAGS_EN
  // Zero/negative flags captured alongside the result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zr <= 1'b0;
      ng <= 1'b0;
    end else if (last_c) begin
      zr <= (res_next_c == '0);
      ng <= res_next_c[WIDTH-1];
    end
  end
`endif

endmodule

// File: tb/tb_serial_logic16.sv
// tb_serial_logic16: directed + randomized bench for serial_logic16 with a
// word-level reference model of the four logic operations.
module tb_serial_logic16;

  localparam int unsigned W = 16;
  localparam int unsigned LAT = W + 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] x = '0;
  logic [W-1:0] y = '0;
  logic [1:0]   op = 2'b00;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out;
`ifdef SERIAL_LOGIC_FLAGS_EN
  logic         zr;
  logic         ng;
`endif

  int checks = 0;
  int errors = 0;

  serial_logic16 #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out)
`ifdef SERIAL_LOGIC_FLAGS_EN
    ,
    .zr        (zr),
    .ng        (ng)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [W-1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [1:0] o);
    case (o)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one operand pair; inputs are scrambled right after the handshake
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] o);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("issue_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; x = a; y = b; op = o;
    @(posedge clk); #1;
    in_valid = 1'b0;
    x = W'($urandom); y = W'($urandom); op = 2'($urandom);
  endtask

  // Wait for the result, check it, stall for a while, then hand it off
  task automatic finish_op(input string tag, input logic [W-1:0] exp, input int stall);
    int  n;
    bit  busy_ok;
    n = 0;
    busy_ok = (in_ready === 1'b0);
    while (out_valid !== 1'b1 && n < 40) begin
      @(posedge clk); #1; n++;
      if (in_ready !== 1'b0) busy_ok = 1'b0;
      x = W'($urandom); y = W'($urandom);
    end
    check({tag, "_latency"}, 32'(n), 32'(LAT));
    check({tag, "_busy_in_ready"}, 32'(busy_ok), 32'd1);
    check({tag, "_out"}, 32'(out), 32'(exp));
`ifdef SERIAL_LOGIC_FLAGS_EN
    check({tag, "_zr"}, 32'(zr), 32'(exp == '0));
    check({tag, "_ng"}, 32'(ng), 32'(exp[W-1]));
`endif
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_stall_out"}, 32'(out), 32'(exp));
      check({tag, "_stall_in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_handoff_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_handoff_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   o;

    // Reset state
    @(posedge clk); #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out", 32'(out), 32'd0);
`ifdef SERIAL_LOGIC_FLAGS_EN
    check("rst_zr", 32'(zr), 32'd0);
    check("rst_ng", 32'(ng), 32'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    // The four operations on the reference operands
    issue(16'hF0F0, 16'hFF00, 2'b00); finish_op("and", 16'hF000, 0);
    issue(16'hF0F0, 16'hFF00, 2'b01); finish_op("or",  16'hFFF0, 0);
    issue(16'hF0F0, 16'hFF00, 2'b10); finish_op("xor", 16'h0FF0, 0);
    issue(16'hF0F0, 16'hFF00, 2'b11); finish_op("nand", 16'h0FFF, 0);

    // Backpressure for five cycles
    issue(16'h1357, 16'h00FF, 2'b10); finish_op("bp", 16'h13A8, 5);

    // Operand change during RUN has no effect
    issue(16'h1234, 16'hFFFF, 2'b00);
    x = '0;
    finish_op("hold", 16'h1234, 0);

    // Reset during the 8th RUN clock aborts the operation
    issue(16'h5A5A, 16'h0F0F, 2'b01);
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out", 32'(out), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    issue(16'hAAAA, 16'hFFFF, 2'b00); finish_op("post_rst", 16'hAAAA, 0);

    // Flag corner cases: all-zero and all-one results
    issue(16'hAAAA, 16'h5555, 2'b00); finish_op("flag_zero", 16'h0000, 1);
    issue(16'hAAAA, 16'h5555, 2'b01); finish_op("flag_neg", 16'hFFFF, 1);

    // Randomized operations against the word-level model
    for (int k = 0; k < 24; k++) begin
      a = W'($urandom);
      b = W'($urandom);
      o = 2'($urandom);
      issue(a, b, o);
      finish_op("rand", ref_op(a, b, o), int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
